// File: rtl/muldiv_seq.sv
`default_nettype none
// =============================================================================
// Module   : muldiv_seq
// Brief    : Multi-cycle M-extension unit; radix-2 shift-add multiply and
//            restoring divide on a shared sequencer. Optional macro
//            MULDIV_FAST_MUL_EN gives single-cycle multiply in FIX.
// Revision : 1.0 - initial release
// =============================================================================
module muldiv_seq #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      alu_op,
    input  logic [XLEN-1:0] operator_1,
    input  logic [XLEN-1:0] operator_2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);
    localparam int c_HALF = XLEN / 2;
    localparam int c_DW   = 2 * XLEN;
    localparam int c_CW   = $clog2(XLEN);
    localparam logic [XLEN-1:0]   c_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [c_HALF-1:0] c_MINH = {1'b1, {(c_HALF-1){1'b0}}};

    localparam logic [4:0] c_ALU_MUL    = 5'h10;
    localparam logic [4:0] c_ALU_MULH   = 5'h11;
    localparam logic [4:0] c_ALU_MULHSU = 5'h12;
    localparam logic [4:0] c_ALU_MULHU  = 5'h13;
    localparam logic [4:0] c_ALU_DIV    = 5'h14;
    localparam logic [4:0] c_ALU_DIVU   = 5'h15;
    localparam logic [4:0] c_ALU_REM    = 5'h16;
    localparam logic [4:0] c_ALU_REMU   = 5'h17;
    localparam logic [4:0] c_ALU_MULW   = 5'h18;
    localparam logic [4:0] c_ALU_DIVW   = 5'h1C;
    localparam logic [4:0] c_ALU_DIVUW  = 5'h1D;
    localparam logic [4:0] c_ALU_REMW   = 5'h1E;
    localparam logic [4:0] c_ALU_REMUW  = 5'h1F;

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

    state_t            r_state;
    logic [c_CW-1:0]   r_count;
    logic              r_isMul, r_isW, r_isRem, r_hiSel, r_resNeg;
    logic [c_DW-1:0]   r_acc, r_mcand;
    logic [XLEN-1:0]   r_mplier, r_quo, r_rem, r_div;

    logic              w_isM, w_isMul, w_isW, w_isRem, w_hiSel, w_s1Signed, w_s2Signed;
    logic [XLEN-1:0]   w_op1, w_op2, w_mag1, w_mag2, w_sextLo1, w_special;
    logic              w_neg1, w_neg2, w_div0, w_ovf, w_specialCase;

    always_comb begin
        w_isM = 1'b1; w_isMul = 1'b0; w_isW = 1'b0; w_isRem = 1'b0;
        w_hiSel = 1'b0; w_s1Signed = 1'b0; w_s2Signed = 1'b0;
        case (alu_op)
            c_ALU_MUL:    w_isMul = 1'b1;
            c_ALU_MULH:   begin w_isMul = 1'b1; w_hiSel = 1'b1; w_s1Signed = 1'b1; w_s2Signed = 1'b1; end
            c_ALU_MULHSU: begin w_isMul = 1'b1; w_hiSel = 1'b1; w_s1Signed = 1'b1; end
            c_ALU_MULHU:  begin w_isMul = 1'b1; w_hiSel = 1'b1; end
            c_ALU_MULW:   begin w_isMul = 1'b1; w_isW = 1'b1; end
            c_ALU_DIV:    begin w_s1Signed = 1'b1; w_s2Signed = 1'b1; end
            c_ALU_DIVU:   ;
            c_ALU_REM:    begin w_isRem = 1'b1; w_s1Signed = 1'b1; w_s2Signed = 1'b1; end
            c_ALU_REMU:   w_isRem = 1'b1;
            c_ALU_DIVW:   begin w_isW = 1'b1; w_s1Signed = 1'b1; w_s2Signed = 1'b1; end
            c_ALU_DIVUW:  w_isW = 1'b1;
            c_ALU_REMW:   begin w_isW = 1'b1; w_isRem = 1'b1; w_s1Signed = 1'b1; w_s2Signed = 1'b1; end
            c_ALU_REMUW:  begin w_isW = 1'b1; w_isRem = 1'b1; end
            default:      w_isM = 1'b0;
        endcase
    end

    // Operand preparation: W narrowing, then sign/magnitude split.
    always_comb begin
        w_op1 = operator_1;
        w_op2 = operator_2;
        if (w_isW) begin
            w_op1 = {{c_HALF{w_s1Signed & operator_1[c_HALF-1]}}, operator_1[c_HALF-1:0]};
            w_op2 = {{c_HALF{w_s2Signed & operator_2[c_HALF-1]}}, operator_2[c_HALF-1:0]};
        end
        w_neg1    = w_s1Signed & w_op1[XLEN-1];
        w_neg2    = w_s2Signed & w_op2[XLEN-1];
        w_mag1    = w_neg1 ? -w_op1 : w_op1;
        w_mag2    = w_neg2 ? -w_op2 : w_op2;
        w_sextLo1 = {{c_HALF{operator_1[c_HALF-1]}}, operator_1[c_HALF-1:0]};
        w_div0    = w_isM & ~w_isMul & (w_op2 == '0);
        w_ovf     = w_isM & ~w_isMul & w_s2Signed &
                    (w_isW ? (operator_1[c_HALF-1:0] == c_MINH && operator_2[c_HALF-1:0] == '1)
                           : (operator_1 == c_MIN && operator_2 == '1));
        w_specialCase = ~w_isM | w_div0 | w_ovf;
        if (!w_isM)       w_special = '0;
        else if (w_div0)  w_special = w_isRem ? (w_isW ? w_sextLo1 : operator_1) : '1;
        else if (w_isRem) w_special = '0;
        else              w_special = w_isW ? {{c_HALF{1'b1}}, c_MINH} : c_MIN;
    end

    logic [XLEN:0]     w_remSh, w_diff;
    logic [c_CW-1:0]   w_lastCount;
    logic [c_DW-1:0]   w_mulFull, w_mulSigned;
    logic [XLEN-1:0]   w_divRaw, w_divSigned, w_low, w_fixResult;

    assign w_remSh     = {r_rem, r_quo[XLEN-1]};
    assign w_diff      = w_remSh - {1'b0, r_div};
    assign w_lastCount = r_isW ? c_CW'(c_HALF - 1) : c_CW'(XLEN - 1);

`ifdef MULDIV_FAST_MUL_EN
    assign w_mulFull = c_DW'(r_mcand[XLEN-1:0]) * c_DW'(r_mplier);
`else
    assign w_mulFull = r_acc;
`endif
    assign w_mulSigned = r_resNeg ? -w_mulFull : w_mulFull;
    assign w_divRaw    = r_isRem ? r_rem : r_quo;
    assign w_divSigned = r_resNeg ? -w_divRaw : w_divRaw;
    assign w_low       = r_isMul ? (r_hiSel ? w_mulSigned[c_DW-1:XLEN] : w_mulSigned[XLEN-1:0])
                                 : w_divSigned;
    assign w_fixResult = r_isW ? {{c_HALF{w_low[c_HALF-1]}}, w_low[c_HALF-1:0]} : w_low;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            r_count   <= '0;
        end else if (flush) begin
            r_state   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    in_ready <= 1'b0;
                    r_count  <= '0;
                    r_isMul  <= w_isMul;
                    r_isW    <= w_isW;
                    r_isRem  <= w_isRem;
                    r_hiSel  <= w_hiSel;
                    r_resNeg <= w_isRem ? w_neg1 : (w_neg1 ^ w_neg2);
                    r_acc    <= '0;
                    r_mcand  <= c_DW'(w_mag1);
                    r_mplier <= w_mag2;
                    // W dividends are left-aligned so the MSB feed is the same for both widths.
                    r_quo    <= w_isW ? {w_mag1[c_HALF-1:0], {c_HALF{1'b0}}} : w_mag1;
                    r_rem    <= '0;
                    r_div    <= w_mag2;
                    if (w_specialCase) begin
                        result    <= w_special;
                        out_valid <= 1'b1;
                        r_state   <= DONE;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    else if (w_isMul) r_state <= FIX;
`endif
                    else r_state <= CALC;
                end
                CALC: begin
                    if (r_isMul) begin
                        if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                    end else begin
                        r_rem <= w_diff[XLEN] ? w_remSh[XLEN-1:0] : w_diff[XLEN-1:0];
                        r_quo <= {r_quo[XLEN-2:0], ~w_diff[XLEN]};
                    end
                    r_count <= r_count + 1'b1;
                    if (r_count == w_lastCount) r_state <= FIX;
                end
                FIX: begin
                    result    <= w_fixResult;
                    out_valid <= 1'b1;
                    r_state   <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire
